if_fetch_ctrl: RTL and testbench

Instruction-fetch controller sitting between the PC register stage and the instruction-memory port of the five-stage MIPS core. Owns the fetch PC and chooses each next fetch address by fixed priority: exception flush, then pending branch redirect, then sequential. Runs a single-outstanding req/addr_ok/data_ok handshake with the instruction bus and discards responses belonging to squashed fetches. Delivers (pc, inst) pairs to decode through a two-deep output buffer that honours the decode stall.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_out_buf.sv | 62 ++++++
 rtl/if_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;

endpackage

// File: rtl/if_out_buf.sv
// Two-deep (out-reg + skid) delivery buffer between fetch and decode.
module if_out_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              ld_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] inst_i,
  output logic              out_v_o,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [ADDR_W-1:0] out_inst_o,
  output logic              skid_v_o
);

  logic              out_v_q, skid_v_q;
  logic [ADDR_W-1:0] out_pc_q, out_inst_q, skid_pc_q, skid_inst_q;
  logic              consume;

  assign consume = out_v_q & ~stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q     <= 1'b0;
      skid_v_q    <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else if (flush_i) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (consume && skid_v_q) begin
      // Older skid entry advances first so delivery order is preserved.
      out_pc_q   <= skid_pc_q;
      out_inst_q <= skid_inst_q;
      skid_v_q   <= ld_i;
      if (ld_i) begin
        skid_pc_q   <= pc_i;
        skid_inst_q <= inst_i;
      end
    end else if (!out_v_q || consume) begin
      out_v_q <= ld_i;
      if (ld_i) begin
        out_pc_q   <= pc_i;
        out_inst_q <= inst_i;
      end
    end else if (ld_i && !skid_v_q) begin
      skid_v_q    <= 1'b1;
      skid_pc_q   <= pc_i;
      skid_inst_q <= inst_i;
    end
  end

  assign out_v_o    = out_v_q;
  assign out_pc_o   = out_pc_q;
  assign out_inst_o = out_inst_q;
  assign skid_v_o   = skid_v_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-PC owner: single-outstanding instruction-bus handshake with
// flush/branch redirect and squashed-response discard.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              stall_i,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [ADDR_W-1:0] inst_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_inst
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, rdr_pc_q, pend_tgt_q, nxt_addr;
  logic              rdr_q, pend_br_q, kill_q, kill_d;
  logic              issue, ld, skid_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    issue   = 1'b0;
    ld      = 1'b0;
    unique case (state_q)
      IDLE: issue = flush_i | ~skid_v;
      // A flush against an unaccepted request keeps the request up (the bus
      // may not see it withdrawn) and squashes its response instead.
      REQ: begin
        if (inst_addr_ok) begin
          state_d = (kill_q | flush_i) ? DROP : WAIT;
          kill_d  = 1'b0;
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          if (flush_i) begin
            issue = 1'b1;
          end else begin
            ld    = 1'b1;
            issue = ~(skid_v | (if_valid & stall_i));
            if (!issue) state_d = IDLE;
          end
        end else if (flush_i) begin
          state_d = DROP;
        end
      end
      DROP:    issue = inst_data_ok;
      default: state_d = IDLE;
    endcase
    if (issue) state_d = REQ;
  end

  always_comb inst_req = (state_q == REQ);
  assign inst_addr = fetch_pc_q;

  // rdr holds a redirect still owed to the bus: reset vector or deferred flush.
  always_comb begin
    if (flush_i)            nxt_addr = flush_pc_i;
    else if (rdr_q)         nxt_addr = rdr_pc_q;
    else if (branch_flag_i) nxt_addr = branch_target_i;
    else if (pend_br_q)     nxt_addr = pend_tgt_q;
    else                    nxt_addr = fetch_pc_q + ADDR_W'(4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rdr_q      <= 1'b1;
      rdr_pc_q   <= RESET_PC;
      pend_br_q  <= 1'b0;
      pend_tgt_q <= '0;
      kill_q     <= 1'b0;
    end else begin
      kill_q <= kill_d;
      if (issue) fetch_pc_q <= nxt_addr;
      if (issue) begin
        rdr_q <= 1'b0;
      end else if (flush_i) begin
        rdr_q    <= 1'b1;
        rdr_pc_q <= flush_pc_i;
      end
      if (flush_i) begin
        pend_br_q <= 1'b0;
      end else if (issue && !rdr_q) begin
        pend_br_q <= 1'b0;
      end else if (branch_flag_i) begin
        pend_br_q  <= 1'b1;
        pend_tgt_q <= branch_target_i;
      end
    end
  end

  if_out_buf #(.ADDR_W(ADDR_W)) u_out_buf (
    .clk        (clk),
    .rst_n      (rst),
    .flush_i    (flush_i),
    .stall_i    (stall_i),
    .ld_i       (ld),
    .pc_i       (fetch_pc_q),
    .inst_i     (inst_rdata),
    .out_v_o    (if_valid),
    .out_pc_o   (if_pc),
    .out_inst_o (if_inst),
    .skid_v_o   (skid_v)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: gated bus model plus request/delivery scoreboards.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, branch_flag_i, stall_i;
  logic [31:0] flush_pc_i, branch_target_i;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;

  int          cyc = 0;
  int          checks = 0, errors = 0;
  int          lat = 0;
  int          rel;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];
  int          pop_cyc[$];
  logic [31:0] mon_e, prev_addr;
  logic        prev_hold = 1'b0;

  if_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .stall_i         (stall_i),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic push(input logic [31:0] a, input bit deliver);
    exp_addr.push_back(a);
    if (deliver) exp_pc.push_back(a);
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while ((exp_addr.size() != 0 || exp_pc.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < maxc), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_grant(input string tag, input int sz);
    int n = 0;
    while (exp_addr.size() == sz && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 40), 32'd1);
  endtask

  // Bus: accepts only addresses the scoreboard expects, answers after lat cycles.
  initial begin : bus
    bit          pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 0; cnt = 0; paddr = '0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
    forever begin
      @(posedge clk); #1;
      inst_addr_ok = 0;
      inst_data_ok = 0;
      if (pend) begin
        if (cnt == 0) begin
          inst_data_ok = 1;
          inst_rdata   = inst_of(paddr);
          pend         = 0;
        end else cnt--;
      end else if (inst_req && exp_addr.size() != 0) begin
        chk("req_addr", inst_addr, exp_addr.pop_front());
        inst_addr_ok = 1;
        pend         = 1;
        cnt          = lat;
        paddr        = inst_addr;
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      if (rst && if_valid && !stall_i) begin
        if (exp_pc.size() == 0) chk("spurious_out", 32'(if_valid), 32'd0);
        else begin
          mon_e = exp_pc.pop_front();
          chk("if_pc", if_pc, mon_e);
          chk("if_inst", if_inst, inst_of(mon_e));
          pop_cyc.push_back(cyc);
        end
      end
      if (rst && prev_hold) begin
        chk("req_hold", 32'(inst_req), 32'd1);
        chk("addr_hold", inst_addr, prev_addr);
      end
      prev_hold = rst && inst_req && !inst_addr_ok;
      prev_addr = inst_addr;
    end
  end

  initial begin : main
    rst = 0; flush_i = 0; flush_pc_i = '0; branch_flag_i = 0;
    branch_target_i = '0; stall_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(inst_req), 32'd0);
    chk("rst_addr", inst_addr, 32'hbfc00000);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);

    // sequential fetch after reset, zero-wait bus
    for (int i = 0; i < 3; i++) push(32'hbfc00000 + 32'(4 * i), 1);
    @(posedge clk); #1 rst = 1; rel = cyc;
    @(posedge clk); @(negedge clk);
    chk("first_req", 32'(inst_req), 32'd1);
    chk("first_addr", inst_addr, 32'hbfc00000);
    drain("seq_drain", 40);
    chk("pop_count", 32'(pop_cyc.size()), 32'd3);
    chk("lat_first", 32'(pop_cyc[0] - rel), 32'd3);
    chk("lat_third", 32'(pop_cyc[2] - rel), 32'd7);

    // branch while delay slot is in flight
    lat = 3;
    push(32'hbfc0000c, 1); push(32'h80001000, 1); push(32'h80001004, 1);
    wait_grant("br_grant", 3);
    @(posedge clk); #1 branch_flag_i = 1; branch_target_i = 32'h80001000;
    @(posedge clk); #1 branch_flag_i = 0;
    drain("br_drain", 60);

    // flush while waiting: response discarded
    push(32'h80001008, 0); push(32'h80000180, 1); push(32'h80000184, 1);
    wait_grant("fl_grant", 3);
    @(posedge clk); #1 flush_i = 1; flush_pc_i = 32'h80000180;
    @(posedge clk); #1 flush_i = 0;
    @(negedge clk);
    chk("drop_req", 32'(inst_req), 32'd0);
    chk("drop_valid", 32'(if_valid), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("redir_req", 32'(inst_req), 32'd1);
    chk("redir_addr", inst_addr, 32'h80000180);
    drain("fl_drain", 60);

    // decode stall fills out and skid, fetch pauses
    lat = 0;
    @(posedge clk); #1 stall_i = 1;
    @(negedge clk);
    push(32'h80000188, 1); push(32'h8000018c, 1);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 32'(inst_req), 32'd0);
      @(negedge clk);
    end
    chk("stall_valid", 32'(if_valid), 32'd1);
    chk("stall_pc", if_pc, 32'h80000188);
    chk("stall_fetched", 32'(exp_addr.size()), 32'd0);
    chk("stall_held", 32'(exp_pc.size()), 32'd2);
    @(posedge clk); #1 stall_i = 0;
    drain("stall_drain", 40);

    // flush and branch together: flush wins
    lat = 3;
    push(32'h80000190, 0); push(32'h80000200, 1); push(32'h80000204, 1);
    wait_grant("fb_grant", 3);
    @(posedge clk); #1
    flush_i = 1; flush_pc_i = 32'h80000200;
    branch_flag_i = 1; branch_target_i = 32'h90000000;
    @(posedge clk); #1 flush_i = 0; branch_flag_i = 0;
    drain("fb_drain", 60);

    // reset during WAIT, late response after release ignored
    lat = 6;
    push(32'h80000208, 0);
    wait_grant("rs_grant", 1);
    @(posedge clk); #1 rst = 0; lat = 0;
    @(negedge clk);
    chk("mid_rst_req", 32'(inst_req), 32'd0);
    chk("mid_rst_addr", inst_addr, 32'hbfc00000);
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    push(32'hbfc00000, 1); push(32'hbfc00004, 1);
    @(posedge clk); @(posedge clk); #1 rst = 1;
    drain("rs_drain", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
